// File: rtl/fetch_arbiter.sv
// fetch_arbiter: two IF stages share one instruction-memory port, with at most one fetch outstanding.
// Define FETCH_ARB_FIXED_PRIO_EN to make core 0 always win ties instead of using round-robin.
module fetch_arbiter #(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic        flush0,
  input  logic        flush1,
  output logic        grant0,
  output logic        grant1,
  output logic        valid0,
  output logic        valid1,
  output logic [31:0] instr0,
  output logic [31:0] instr1,
  output logic        stall0,
  output logic        stall1,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        err
);

  typedef enum logic {IDLE, WAIT} state_e;

  localparam logic [7:0] LastCnt = 8'(MAX_WAIT - 1);

  state_e      state_q;
  logic        owner_q;
  logic        discard_q;
  logic [7:0]  count_q;
  logic        grant0_q;
  logic        grant1_q;
  logic        valid0_q;
  logic        valid1_q;
  logic [31:0] instr0_q;
  logic [31:0] instr1_q;
  logic        err_q;

  logic        winner;
  logic        accept;
  logic        ownerFlush;

`ifdef FETCH_ARB_FIXED_PRIO_EN
  assign winner = ~req0;
`else
  logic        ptr_q;
  assign winner = (req0 & req1) ? ptr_q : req1;
`endif

  // Memory is only offered a request while no fetch is outstanding.
  assign mem_req    = (state_q == IDLE) & (req0 | req1);
  assign mem_addr   = (state_q == IDLE) ? (winner ? addr1 : addr0) : 32'h0;
  assign accept     = mem_req & mem_ready;
  assign ownerFlush = owner_q ? flush1 : flush0;

  assign grant0 = grant0_q;
  assign grant1 = grant1_q;
  assign valid0 = valid0_q;
  assign valid1 = valid1_q;
  assign instr0 = instr0_q;
  assign instr1 = instr1_q;
  assign err    = err_q;
  assign stall0 = req0 & ~valid0_q;
  assign stall1 = req1 & ~valid1_q;

  // Grant, valid and err are registered pulses, visible the cycle after the event that causes them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
`ifndef FETCH_ARB_FIXED_PRIO_EN
      ptr_q     <= 1'b0;
`endif
      owner_q   <= 1'b0;
      discard_q <= 1'b0;
      count_q   <= 8'd0;
      grant0_q  <= 1'b0;
      grant1_q  <= 1'b0;
      valid0_q  <= 1'b0;
      valid1_q  <= 1'b0;
      instr0_q  <= 32'h0;
      instr1_q  <= 32'h0;
      err_q     <= 1'b0;
    end else begin
      grant0_q <= 1'b0;
      grant1_q <= 1'b0;
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
      err_q    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            grant0_q  <= ~winner;
            grant1_q  <= winner;
            owner_q   <= winner;
            discard_q <= 1'b0;
            count_q   <= 8'd0;
`ifndef FETCH_ARB_FIXED_PRIO_EN
            ptr_q     <= ~winner;
`endif
            state_q   <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            state_q <= IDLE;
            if (!discard_q && !ownerFlush) begin
              if (owner_q) begin
                valid1_q <= 1'b1;
                instr1_q <= mem_rdata;
              end else begin
                valid0_q <= 1'b1;
                instr0_q <= mem_rdata;
              end
            end
          end else begin
            if (ownerFlush) discard_q <= 1'b1;
            count_q <= count_q + 8'd1;
            // The wait that brings the count to MAX_WAIT is the last one allowed.
            if (count_q == LastCnt) begin
              state_q <= IDLE;
              err_q   <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_arbiter.sv
// tb_fetch_arbiter: directed scenarios plus randomized traffic checked against a transaction-level model.
// Honours FETCH_ARB_FIXED_PRIO_EN so the same bench covers both arbitration modes.
module tb_fetch_arbiter;

  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, flush0, flush1;
  logic [31:0] addr0, addr1;
  logic        mem_ready, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        grant0, grant1, valid0, valid1, stall0, stall1, mem_req, err;
  logic [31:0] instr0, instr1, mem_addr;

  always #5 clk = ~clk;

  fetch_arbiter #(.MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .flush0(flush0), .flush1(flush1),
    .grant0(grant0), .grant1(grant1), .valid0(valid0), .valid1(valid1),
    .instr0(instr0), .instr1(instr1), .stall0(stall0), .stall1(stall1),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .err(err)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: one outstanding fetch described as a transaction record.
  bit          mBusy;
  int          mCore;
  bit          mKilled;
  int          mWaited;
  int          mFavour;
  bit          eGrant[2];
  bit          eValid[2];
  logic [31:0] eInstr[2];
  bit          eErr;

  function automatic int pickWinner();
`ifdef FETCH_ARB_FIXED_PRIO_EN
    return req0 ? 0 : 1;
`else
    if (req0 && req1) return mFavour;
    return req1 ? 1 : 0;
`endif
  endfunction

  task automatic modelReset();
    mBusy = 0; mCore = 0; mKilled = 0; mWaited = 0; mFavour = 0;
    eGrant[0] = 0; eGrant[1] = 0; eValid[0] = 0; eValid[1] = 0;
    eInstr[0] = 32'h0; eInstr[1] = 32'h0; eErr = 0;
  endtask

  task automatic modelEdge();
    bit ownerFlush;
    int w;
    eGrant[0] = 0; eGrant[1] = 0; eValid[0] = 0; eValid[1] = 0; eErr = 0;
    ownerFlush = (mCore == 0) ? flush0 : flush1;
    if (!mBusy) begin
      if ((req0 || req1) && mem_ready) begin
        w = pickWinner();
        eGrant[w] = 1;
        mBusy = 1; mCore = w; mKilled = 0; mWaited = 0;
        mFavour = 1 - w;
      end
    end else if (mem_rvalid) begin
      mBusy = 0;
      if (!mKilled && !ownerFlush) begin
        eValid[mCore] = 1;
        eInstr[mCore] = mem_rdata;
      end
    end else begin
      if (ownerFlush) mKilled = 1;
      mWaited++;
      if (mWaited == MAXW) begin
        mBusy = 0;
        eErr = 1;
      end
    end
  endtask

  task automatic cycle();
    modelEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    req0 = 0; req1 = 0; flush0 = 0; flush1 = 0;
    addr0 = 32'h0; addr1 = 32'h0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = 32'h0;
  endtask

  task automatic applyReset();
    clearInputs();
    rst = 0;
    modelReset();
    #2;
    rst = 1;
  endtask

  task automatic test_reset();
    clearInputs();
    rst = 0;
    modelReset();
    @(posedge clk); #1;
    vectors++; if ({grant0, grant1, valid0, valid1, err} !== 5'b0) begin miscompares++; $display("[TB] FAIL reset_pulses: got %b expected 00000", {grant0, grant1, valid0, valid1, err}); end
    vectors++; if (instr0 !== 32'h0 || instr1 !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_instr: got %h/%h expected 0/0", instr0, instr1); end
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_mem_req: got %b expected 0", mem_req); end
    req0 = 1; mem_ready = 1;
    @(posedge clk); #1;
    vectors++; if (grant0 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_no_grant: got %b expected 0", grant0); end
    clearInputs();
    rst = 1;
  endtask

  task automatic test_single_fetch();
    req0 = 1; addr0 = 32'h100; mem_ready = 1;
    #1;
    vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("[TB] FAIL s1_mem_req: got %b expected 1", mem_req); end
    vectors++; if (mem_addr !== 32'h100) begin miscompares++; $display("[TB] FAIL s1_mem_addr: got %h expected 00000100", mem_addr); end
    vectors++; if (stall0 !== 1'b1) begin miscompares++; $display("[TB] FAIL s1_stall_before: got %b expected 1", stall0); end
    cycle();
    vectors++; if (grant0 !== 1'b1 || grant1 !== 1'b0) begin miscompares++; $display("[TB] FAIL s1_grant: got %b%b expected 10", grant0, grant1); end
    mem_ready = 0;
    #1;
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL s1_mem_req_wait: got %b expected 0", mem_req); end
    cycle();
    mem_rvalid = 1; mem_rdata = 32'h00500093;
    cycle();
    mem_rvalid = 0;
    #1;
    vectors++; if (valid0 !== 1'b1) begin miscompares++; $display("[TB] FAIL s1_valid: got %b expected 1", valid0); end
    vectors++; if (instr0 !== 32'h00500093) begin miscompares++; $display("[TB] FAIL s1_instr: got %h expected 00500093", instr0); end
    vectors++; if (stall0 !== 1'b0) begin miscompares++; $display("[TB] FAIL s1_stall_low: got %b expected 0", stall0); end
    cycle();
    vectors++; if (valid0 !== 1'b0 || stall0 !== 1'b1) begin miscompares++; $display("[TB] FAIL s1_after: got valid %b stall %b expected valid 0 stall 1", valid0, stall0); end
    vectors++; if (instr0 !== 32'h00500093) begin miscompares++; $display("[TB] FAIL s1_instr_hold: got %h expected 00500093", instr0); end
    clearInputs();
  endtask

  task automatic test_round_robin();
    int expCore;
    applyReset();
    for (int k = 0; k < 4; k++) begin
`ifdef FETCH_ARB_FIXED_PRIO_EN
      expCore = 0;
`else
      expCore = k % 2;
`endif
      req0 = 1; req1 = 1; addr0 = 32'h1000 + k; addr1 = 32'h2000 + k;
      mem_ready = 1; mem_rvalid = 0;
      #1;
      vectors++; if (mem_addr !== ((expCore == 1) ? addr1 : addr0)) begin miscompares++; $display("[TB] FAIL rr_addr%0d: got %h expected core %0d", k, mem_addr, expCore); end
      cycle();
      vectors++; if (grant0 !== (expCore == 0) || grant1 !== (expCore == 1)) begin miscompares++; $display("[TB] FAIL rr_grant%0d: got %b%b expected core %0d", k, grant0, grant1, expCore); end
      mem_rvalid = 1; mem_rdata = 32'hA0 + k;
      cycle();
      vectors++; if ((expCore == 0 ? valid0 : valid1) !== 1'b1 || (expCore == 0 ? instr0 : instr1) !== 32'hA0 + k) begin miscompares++; $display("[TB] FAIL rr_data%0d: got v%b%b %h/%h expected core %0d data %h", k, valid0, valid1, instr0, instr1, expCore, 32'hA0 + k); end
    end
    clearInputs();
  endtask

  task automatic test_flush();
    logic [31:0] prevInstr1;
    prevInstr1 = eInstr[1];
    req1 = 1; addr1 = 32'h200; mem_ready = 1;
    cycle();
    vectors++; if (grant1 !== 1'b1) begin miscompares++; $display("[TB] FAIL s3_grant1: got %b expected 1", grant1); end
    mem_ready = 0; flush1 = 1;
    cycle();
    flush1 = 0; mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
    cycle();
    mem_rvalid = 0;
    vectors++; if (valid1 !== 1'b0) begin miscompares++; $display("[TB] FAIL s3_no_valid: got %b expected 0", valid1); end
    vectors++; if (instr1 !== prevInstr1) begin miscompares++; $display("[TB] FAIL s3_instr_kept: got %h expected %h", instr1, prevInstr1); end
    #1;
    vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("[TB] FAIL s3_back_idle: got %b expected 1", mem_req); end
    clearInputs();
  endtask

  task automatic test_watchdog();
    req0 = 1; addr0 = 32'h300; mem_ready = 1;
    cycle();
    vectors++; if (grant0 !== 1'b1) begin miscompares++; $display("[TB] FAIL s4_grant: got %b expected 1", grant0); end
    mem_ready = 0;
    for (int i = 1; i <= MAXW; i++) begin
      cycle();
      vectors++; if (err !== (i == MAXW) || mem_req !== (i == MAXW)) begin miscompares++; $display("[TB] FAIL s4_wait%0d: got err %b mem_req %b expected %b", i, err, mem_req, (i == MAXW)); end
    end
    cycle();
    vectors++; if (err !== 1'b0 || valid0 !== 1'b0) begin miscompares++; $display("[TB] FAIL s4_single_pulse: got err %b valid %b expected 0 0", err, valid0); end
    clearInputs();
  endtask

  task automatic test_reset_mid_wait();
    req0 = 1; addr0 = 32'h300; mem_ready = 1;
    cycle();
    vectors++; if (grant0 !== 1'b1) begin miscompares++; $display("[TB] FAIL s5_grant: got %b expected 1", grant0); end
    clearInputs();
    #2;
    rst = 0;
    modelReset();
    #1;
    vectors++; if ({grant0, grant1, valid0, valid1, err} !== 5'b0) begin miscompares++; $display("[TB] FAIL s5_async_clear: got %b expected 00000", {grant0, grant1, valid0, valid1, err}); end
    vectors++; if (instr0 !== 32'h0 || instr1 !== 32'h0) begin miscompares++; $display("[TB] FAIL s5_instr_clear: got %h/%h expected 0/0", instr0, instr1); end
    @(posedge clk); #1;
    rst = 1;
    mem_rvalid = 1; mem_rdata = 32'hCAFEF00D;
    cycle();
    mem_rvalid = 0;
    vectors++; if (valid0 !== 1'b0 || valid1 !== 1'b0 || instr0 !== 32'h0) begin miscompares++; $display("[TB] FAIL s5_late_rvalid: got v%b%b instr0 %h expected v00 0", valid0, valid1, instr0); end
    req0 = 1; req1 = 1; addr0 = 32'h500; addr1 = 32'h600; mem_ready = 1;
    #1;
    vectors++; if (mem_addr !== 32'h500) begin miscompares++; $display("[TB] FAIL s5_ptr_addr: got %h expected 00000500", mem_addr); end
    cycle();
    vectors++; if (grant0 !== 1'b1 || grant1 !== 1'b0) begin miscompares++; $display("[TB] FAIL s5_ptr_grant: got %b%b expected 10", grant0, grant1); end
    clearInputs();
  endtask

  task automatic test_random();
    bit expReq;
    applyReset();
    for (int n = 0; n < 400; n++) begin
      req0 = ($urandom_range(0, 9) < 7);
      req1 = ($urandom_range(0, 9) < 7);
      addr0 = $urandom; addr1 = $urandom;
      flush0 = ($urandom_range(0, 9) == 0);
      flush1 = ($urandom_range(0, 9) == 0);
      mem_ready = ($urandom_range(0, 9) < 6);
      mem_rvalid = ($urandom_range(0, 9) < 4);
      mem_rdata = $urandom;
      #1;
      expReq = !mBusy && (req0 || req1);
      vectors++; if (mem_req !== expReq) begin miscompares++; $display("[TB] FAIL rnd_mem_req@%0d: got %b expected %b", n, mem_req, expReq); end
      if (expReq) begin
        vectors++; if (mem_addr !== ((pickWinner() == 1) ? addr1 : addr0)) begin miscompares++; $display("[TB] FAIL rnd_mem_addr@%0d: got %h expected core %0d", n, mem_addr, pickWinner()); end
      end
      vectors++; if (stall0 !== (req0 && !eValid[0]) || stall1 !== (req1 && !eValid[1])) begin miscompares++; $display("[TB] FAIL rnd_stall@%0d: got %b%b expected %b%b", n, stall0, stall1, (req0 && !eValid[0]), (req1 && !eValid[1])); end
      cycle();
      vectors++; if (grant0 !== eGrant[0] || grant1 !== eGrant[1]) begin miscompares++; $display("[TB] FAIL rnd_grant@%0d: got %b%b expected %b%b", n, grant0, grant1, eGrant[0], eGrant[1]); end
      vectors++; if (valid0 !== eValid[0] || valid1 !== eValid[1]) begin miscompares++; $display("[TB] FAIL rnd_valid@%0d: got %b%b expected %b%b", n, valid0, valid1, eValid[0], eValid[1]); end
      vectors++; if (instr0 !== eInstr[0] || instr1 !== eInstr[1]) begin miscompares++; $display("[TB] FAIL rnd_instr@%0d: got %h/%h expected %h/%h", n, instr0, instr1, eInstr[0], eInstr[1]); end
      vectors++; if (err !== eErr) begin miscompares++; $display("[TB] FAIL rnd_err@%0d: got %b expected %b", n, err, eErr); end
    end
    clearInputs();
  endtask

  initial begin
    rst = 0;
    clearInputs();
    test_reset();
    test_single_fetch();
    test_round_robin();
    test_flush();
    test_watchdog();
    test_reset_mid_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete within 200000 time units");
    $fatal(1, "[TB] timeout");
  end

endmodule
